// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline-stage registers: occupancy state, stage payload
// structs and the bubble payload constants built from NOP_INSTR / RESET_PC.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_BUSY  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_reg_t;

  localparam int IF_ID_W = $bits(if_id_reg_t);

  // Bubble for IF/ID: a NOP fetched at the reset vector.
  localparam if_id_reg_t NOP_IF_ID = '{
    pc:       RESET_PC,
    instr:    NOP_INSTR,
    pc_plus4: RESET_PC + 32'd4
  };

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall, flush and
// an optional second (skid) entry that lets in_ready come straight from a flop.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH       = 96,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0,
  parameter bit               REG_READY   = 1'b1,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Handshake: a transfer happens on a rising clk edge when valid & ready are
  // both high (out side additionally needs !stall); valid never depends on ready.
  occ_e             state, state_next;
  logic [WIDTH-1:0] main_data, main_next;
  logic [WIDTH-1:0] skid_data, skid_next;
  logic             in_fire, out_fire;

  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = main_data;
  assign occupancy = state;
  assign out_fire  = out_valid & out_ready & ~stall;
  assign in_ready  = REG_READY ? (state != OCC_FULL)
                               : (~out_valid | (out_ready & ~stall));
  assign in_fire   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OCC_EMPTY;
      main_data <= NOP_PAYLOAD;
      skid_data <= NOP_PAYLOAD;
    end else begin
      state     <= state_next;
      main_data <= main_next;
      skid_data <= skid_next;
    end
  end

  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    case (state)
      OCC_EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = OCC_BUSY;
        end
      end
      OCC_BUSY: begin
        if (out_fire && in_fire) begin
          main_next = in_data;
        end else if (out_fire) begin
          main_next  = NOP_PAYLOAD;
          state_next = OCC_EMPTY;
        end else if (in_fire && REG_READY) begin
          skid_next  = in_data;
          state_next = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (out_fire) begin
          main_next  = skid_data;
          state_next = OCC_BUSY;
        end
      end
      default: begin
        main_next  = NOP_PAYLOAD;
        state_next = OCC_EMPTY;
      end
    endcase
    // Flush wins over everything except reset; an out_fire this cycle still went out.
    if (flush) begin
      main_next  = NOP_PAYLOAD;
      state_next = OCC_EMPTY;
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (out_valid & ~out_fire),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (~out_valid),
    .count (bubble_cnt)
  );

endmodule
